// File: rtl/multibank_msg_buffer.sv
// N-bank message buffer: the writer fills one bank at a time, and the reader drains
// whole committed blocks in commit order.
module multibank_msg_buffer_bank (
  input  logic clk,
  input  logic rst,
  input  logic wr_acc,
  input  logic commit,
  input  logic rd_acc,
  input  logic rd_fin,
  output logic readable,
  output logic writable
);
  typedef enum logic [1:0] {FREE, FILLING, READY, DRAINING} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  // Write-side and read-side events never target the same bank in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      FREE:     if (commit) state_nxt = READY;
                else if (wr_acc) state_nxt = FILLING;
      FILLING:  if (commit) state_nxt = READY;
      READY:    if (rd_fin) state_nxt = FREE;
                else if (rd_acc) state_nxt = DRAINING;
      DRAINING: if (rd_fin) state_nxt = FREE;
      default:  state_nxt = FREE;
    endcase
  end

  assign readable = (state == READY) || (state == DRAINING);
  assign writable = (state == FREE) || (state == FILLING);
endmodule

module multibank_msg_buffer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int NUM_BANKS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           wr_last,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_ready,
  input  logic                           rd_en,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid,
  output logic                           rd_last,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(NUM_BANKS+1)-1:0] bank_count,
  output logic                           wr_drop,
  output logic                           rd_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(NUM_BANKS+1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS-1);

  logic [DATA_W-1:0]    mem [NUM_BANKS][DEPTH];
  logic [AW-1:0]        len [NUM_BANKS];
  logic [BW-1:0]        wb, rb;
  logic [AW-1:0]        wa, ra;
  logic [NUM_BANKS-1:0] bank_rd, bank_wr;
  logic                 wr_acc, commit, rd_acc, rd_fin;

  assign wr_ready = bank_wr[wb];
  assign full     = !wr_ready;
  assign empty    = !bank_rd[rb];
  assign wr_acc   = wr_en && wr_ready;
  assign commit   = wr_acc && (wr_last || wa == LAST_ADDR);
  assign rd_acc   = rd_en && !empty;
  assign rd_fin   = rd_acc && (ra == len[rb]);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    multibank_msg_buffer_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_acc   (wr_acc && wb == BW'(b)),
      .commit   (commit && wb == BW'(b)),
      .rd_acc   (rd_acc && rb == BW'(b)),
      .rd_fin   (rd_fin && rb == BW'(b)),
      .readable (bank_rd[b]),
      .writable (bank_wr[b])
    );
  end

  always_comb begin
    bank_count = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_count = bank_count + CW'(bank_rd[b]);
  end

  // Storage carries no reset; stale words are never readable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wb][wa] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb       <= '0;
      wa       <= '0;
      rb       <= '0;
      ra       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      wr_drop  <= 1'b0;
      rd_drop  <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) len[b] <= '0;
    end else begin
      wr_drop  <= wr_en && !wr_ready;
      rd_drop  <= rd_en && empty;
      rd_valid <= rd_acc;
      rd_last  <= rd_fin;
      if (wr_acc) begin
        if (commit) begin
          len[wb] <= wa;
          wa      <= '0;
          wb      <= (wb == LAST_BANK) ? '0 : wb + 1'b1;
        end else begin
          wa <= wa + 1'b1;
        end
      end
      if (rd_acc) begin
        rd_data <= mem[rb][ra];
        if (rd_fin) begin
          ra <= '0;
          rb <= (rb == LAST_BANK) ? '0 : rb + 1'b1;
        end else begin
          ra <= ra + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multibank_msg_buffer.sv
// Directed and random bench for multibank_msg_buffer; the reference is a block queue
// plus a count of occupied banks.
module tb_multibank_msg_buffer;
  localparam int DW = 8, DEPTH = 4, NB = 3, CW = $clog2(NB+1);

  logic          clk = 1'b0, rst = 1'b0;
  logic          wr_en = 1'b0, wr_last = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_valid, rd_last, empty, full, wr_drop, rd_drop;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] bank_count;

  multibank_msg_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_last(wr_last), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .empty(empty), .full(full), .bank_count(bank_count),
    .wr_drop(wr_drop), .rd_drop(rd_drop)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW:0]   cq[$];    // committed words, {last, data}
  logic [DW-1:0] part[$];  // block being written
  int            outst;    // committed blocks not yet fully read

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (part.size() > 0) || (outst < NB);
  endfunction

  task automatic check_status();
    chk("wr_ready", 32'(wr_ready), 32'(m_ready()));
    chk("full", 32'(full), 32'(!m_ready()));
    chk("empty", 32'(empty), 32'(outst == 0));
    chk("bank_count", 32'(bank_count), 32'(outst));
  endtask

  task automatic step(input logic we, input logic wl, input logic [DW-1:0] wd, input logic re);
    bit wacc, racc;
    logic [DW:0] e;
    e = '0;
    wr_en = we; wr_last = wl; wr_data = wd; rd_en = re;
    wacc = we && m_ready();
    racc = re && (outst > 0);
    if (racc) begin
      e = cq.pop_front();
      if (e[DW]) outst--;
    end
    if (wacc) begin
      part.push_back(wd);
      if (wl || part.size() == DEPTH) begin
        for (int i = 0; i < part.size(); i++) cq.push_back({i == part.size() - 1, part[i]});
        part.delete();
        outst++;
      end
    end
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'(racc));
    if (racc) begin
      chk("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
      chk("rd_last", 32'(rd_last), 32'(e[DW]));
    end
    chk("wr_drop", 32'(wr_drop), 32'(we && !wacc));
    chk("rd_drop", 32'(rd_drop), 32'(re && !racc));
    check_status();
  endtask

  task automatic do_reset(input logic busy);
    rst = 1'b1; rd_en = busy; wr_en = busy; wr_data = 8'h99;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    cq.delete(); part.delete(); outst = 0;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_wr_drop", 32'(wr_drop), 0);
    chk("rst_rd_drop", 32'(rd_drop), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    check_status();
  endtask

  initial begin
    outst = 0;
    @(negedge clk);
    do_reset(1'b0);

    // underflow
    step(0, 0, 0, 1);
    chk("underflow_drop", 32'(rd_drop), 1);
    step(0, 0, 0, 0);

    // full-bank transfer
    for (int i = 0; i < 4; i++) step(1, 0, DW'(8'h10 + i), 0);
    chk("fb_count", 32'(bank_count), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("fb_last_data", 32'(rd_data), 32'h13);
    chk("fb_last_flag", 32'(rd_last), 1);
    chk("fb_empty", 32'(empty), 1);

    // short block and length-1 block
    step(1, 0, 8'hA1, 0);
    step(1, 1, 8'hA2, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("short_last", 32'(rd_data), 32'hA2);
    step(0, 0, 0, 1);
    chk("short_drop", 32'(rd_drop), 1);
    step(1, 1, 8'h5A, 0);
    step(0, 0, 0, 1);
    chk("len1_last", 32'(rd_last), 1);

    // fill every bank, then overflow
    for (int i = 0; i < NB * DEPTH; i++) step(1, 0, DW'(8'h30 + i), 0);
    chk("ovf_full", 32'(full), 1);
    step(1, 0, 8'hEE, 0);
    chk("ovf_drop", 32'(wr_drop), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
    chk("ovf_ready_after_drain", 32'(wr_ready), 1);
    for (int i = 0; i < (NB - 1) * DEPTH; i++) step(0, 0, 0, 1);

    // wrap with concurrent streaming reads
    for (int c = 0; c < 24; c++)
      step(c < 20, 0, DW'(((c / 4 + 1) << 4) | (c % 4)), c >= 4);
    chk("wrap_empty", 32'(empty), 1);

    // reset mid-drain with another bank ready
    for (int i = 0; i < 2 * DEPTH; i++) step(1, 0, DW'(8'h60 + i), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    do_reset(1'b1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h77 + i), 0);
    step(0, 0, 0, 1);
    chk("post_rst_first", 32'(rd_data), 32'h77);
    for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 1);

    // random traffic with shifting bias
    for (int c = 0; c < 3000; c++) begin
      int wp, rp;
      wp = ((c / 200) % 3 == 0) ? 85 : ((c / 200) % 3 == 1) ? 30 : 60;
      rp = 100 - wp;
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1) == 1);
      else step($urandom_range(0, 99) < wp, $urandom_range(0, 4) == 0,
                DW'($urandom), $urandom_range(0, 99) < rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multibank_msg_buffer.md
# multibank_msg_buffer

Parametrised N-bank message buffer for the FEC encoder datapath. It is the generalised successor of the two-bank circular (ping-pong) buffer. The writer fills one bank at a time and closes a block either when the bank is full or early with `wr_last`. Committed blocks are handed to the reader whole, in commit order, with per-block length tracking, a last-word flag and drop reporting.

## Interface

Parameters:
- `DATA_W`, 8: message word width.
- `DEPTH`, 16: words per bank; power of two, ≥2.
- `NUM_BANKS`, 2: number of banks; 2..8.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  write request.
- `wr_last`  in  1  closes the current block; only meaningful with `wr_en`.
- `wr_data`  in  DATA_W  write word.
- `wr_ready`  out  1  current write bank can accept a word.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_W  registered read word.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `rd_last`  out  1  `rd_data` is the final word of its block.
- `empty`  out  1  no committed block is available.
- `full`  out  1  equals `!wr_ready`.
- `bank_count`  out  $clog2(NUM_BANKS+1)  number of banks in READY or DRAINING.
- `wr_drop`  out  1  one-cycle pulse: `wr_en` arrived while `!wr_ready`.
- `rd_drop`  out  1  one-cycle pulse: `rd_en` arrived while `empty`.

## Operation

- Bank states:
  - FREE → FILLING on the first accepted write.
  - FILLING → READY on commit.
  - READY → DRAINING on the first accepted read.
  - DRAINING → FREE on the accepted read of the last word.
  - A block of length 1 goes READY → FREE directly.
- Pointers:
  - Write bank `wb`, write address `wa` ($clog2(DEPTH) bits).
  - Read bank `rb`, read address `ra`.
  - Per-bank last index `len[b]` ($clog2(DEPTH) bits).
- Memory: flop array of NUM_BANKS×DEPTH words, indexed {bank, addr}.
- Write accept: `wr_en && wr_ready`. Stores `wr_data` at {wb, wa} and increments `wa`.
- Commit: an accepted write with `wr_last`, or with `wa == DEPTH-1`. Both together cause a single commit.
  - On commit: `len[wb] <= wa`, bank goes READY, `wa <= 0`, `wb <= (wb+1) mod NUM_BANKS`.
- `wr_ready` is combinational: 1 when `state[wb]` is FREE or FILLING.
- Read accept: `rd_en && !empty`.
  - Reads {rb, ra} into `rd_data`.
  - `rd_last` is registered from `ra == len[rb]`.
  - On the last word: `ra <= 0`, bank goes FREE, `rb <= (rb+1) mod NUM_BANKS`.
- `empty` = `state[rb]` is neither READY nor DRAINING. A FILLING bank is never readable; there is no read-through.
- Rejected requests:
  - A dropped write does not store or advance, and produces a `wr_drop` pulse.
  - A dropped read produces a `rd_drop` pulse and leaves `rd_valid` low.
- `wr_last` without `wr_en` is ignored.

## Timing

- Reset (sampled high at an edge) → after that edge:
  - all banks FREE, all pointers 0;
  - `wr_ready` 1, `full` 0, `empty` 1, `bank_count` 0;
  - `rd_valid`, `rd_last`, `wr_drop`, `rd_drop` 0;
  - `rd_data` 0.
- Reset mid-operation discards all stored blocks. The partial block and any in-flight read are lost; no `rd_valid` follows.
- Read latency is 1 cycle: `rd_en` accepted at edge N → `rd_data`/`rd_valid`/`rd_last` valid in the cycle after N, held for one cycle. Reading every cycle gives back-to-back words, including across a block boundary.
- `bank_count` and `empty` update on the cycle after a commit or final read.
- A bank freed by a final read becomes writable (`wr_ready` rises when `wb` points at it) the cycle after that read.
- Simultaneous write and read to different banks are independent; both are accepted in the same cycle.
- Simultaneous commit and final read in one cycle leave `bank_count` unchanged.
- Throughput: 1 word/cycle on each side.

## Test plan

- **Full-bank transfer.** DEPTH=4, NUM_BANKS=2. Write 0x10..0x13.
  - `bank_count` = 1 and `empty` = 0 the cycle after the 4th write.
  - Four `rd_en` → `rd_data` 0x10, 0x11, 0x12, 0x13 each one cycle later; `rd_last` only on 0x13.
  - `empty` = 1 afterwards.
- **Short block.** Write 0xA1, then 0xA2 with `wr_last`.
  - Reads return exactly 0xA1, 0xA2 with `rd_last` on 0xA2; the next `rd_en` → `rd_drop` = 1.
  - `wr_en` + `wr_last` on a FREE bank → length-1 block with `rd_last` on its only word.
- **Full/overflow.** Commit two DEPTH=4 blocks → `wr_ready` 0, `full` 1, `bank_count` 2.
  - Write 0xEE → `wr_drop` pulse; 0xEE never appears on `rd_data`.
  - Drain one block → `wr_ready` 1 the cycle after the final `rd_en`.
- **Underflow.** `rd_en` after reset → `rd_drop` 1 for one cycle, `rd_valid` 0, state unchanged.
- **Wrap and ordering.** NUM_BANKS=3, DEPTH=4. Write 5 blocks tagged 0x1n..0x5n with interleaved continuous reads.
  - All 20 words come out in order with correct `rd_last`.
  - `wb` and `rb` wrap 2 → 0.
  - Concurrent write and read cycles occur with no stalls.
- **Reset mid-drain.** Assert `rst` for 1 cycle while DRAINING with another bank READY.
  - Next cycle: `empty` 1, `bank_count` 0, `rd_valid` 0, `wr_ready` 1.
  - A new block 0x77.. then reads back correctly from bank 0.
